// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared encodings for the Execute/Memory datapath slice:
//               ALU operation codes driven into the ALU and operation classes
//               produced by the main instruction decoder.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

  // ALU operation codes (alu_control / alu_control_in)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Operation classes from the main decoder (alu_op)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // funct3 values that select a specific R/I-type operation
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage : exec_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational 32-bit RV32I ALU with zero flag.
// Ports       : src_a, src_b   - 32-bit operands
//               alu_control    - 3-bit operation code (exec_pkg::ALU_*)
//               alu_result     - 32-bit result
//               zero           - 1 when alu_result is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import exec_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero
);

  logic w_slt;

  // Signed comparison: a set sign bit means a negative operand.
  assign w_slt = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      ALU_ADD: alu_result = src_a + src_b;
      // Subtraction written as two's-complement addition, matching the
      // adder-based datapath it models.
      ALU_SUB: alu_result = src_a + ~src_b + 32'd1;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, w_slt};
      // Unassigned codes produce 0 so that zero asserts for them.
      default: alu_result = 32'd0;
    endcase
  end

  assign zero = (alu_result == 32'd0);

endmodule : alu_core
`default_nettype wire

// File: rtl/exec_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_mem_unit
// Description : Execute/Memory datapath slice of a 5-stage RV32I pipeline.
//               Contains the ALU-control decoder (combinational), the ALU
//               (alu_core, combinational) and a word-addressed data RAM with
//               combinational read, synchronous write and asynchronous clear.
// Parameters  : MEM_WORDS - RAM depth in 32-bit words (power of two, >= 2)
// Ports       : clk, reset            - clock, async active-high reset
//               alu_op, funct3, op5,  - decoder inputs
//               funct7_5
//               alu_control           - decoded ALU operation
//               src_a, src_b,         - ALU operands and pipelined op code
//               alu_control_in
//               alu_result, zero      - ALU outputs
//               mem_write, mem_addr,  - RAM write enable, byte address, data
//               mem_wdata
//               mem_rdata             - RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int MEM_WORDS = 64
)(
  input  logic        clk,
  input  logic        reset,
  // Decoder
  input  logic [1:0]  alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7_5,
  output logic [2:0]  alu_control,
  // ALU
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_control_in,
  output logic [31:0] alu_result,
  output logic        zero,
  // Data RAM
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam int C_IDX_W = $clog2(MEM_WORDS);

  // --------------------------------------------------------------------------
  // ALU-control decoder
  // --------------------------------------------------------------------------
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only a true R-type with instr[30] set is a sub; addi with a
          // negative immediate also has bit 30 set and must stay an add.
          F3_ADDSUB: alu_control = ({op5, funct7_5} == 2'b11) ? ALU_SUB : ALU_ADD;
          F3_SLT:    alu_control = ALU_SLT;
          F3_OR:     alu_control = ALU_OR;
          F3_AND:    alu_control = ALU_AND;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  alu_core u_alu_core (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control_in),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  // --------------------------------------------------------------------------
  // Data RAM
  // --------------------------------------------------------------------------
  logic [31:0]        r_mem [MEM_WORDS];
  logic [C_IDX_W-1:0] w_idx;
  logic               w_unused_addr_bits;

  // Byte offset and upper bits are dropped: no alignment trap, and the
  // address space wraps modulo the RAM depth.
  assign w_idx              = mem_addr[C_IDX_W+1:2];
  assign w_unused_addr_bits = ^{mem_addr[31:C_IDX_W+2], mem_addr[1:0]};

  // Reset is asynchronous and clears every word, so writes are implicitly
  // blocked for as long as reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (mem_write) begin
      r_mem[w_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = r_mem[w_idx];

endmodule : exec_mem_unit
`default_nettype wire

// File: tb/tb_exec_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_mem_unit
// Description : Self-checking bench for exec_mem_unit. Decoder and ALU are
//               checked from vector tables; RAM reads are checked against a
//               reference memory through an expected-value queue.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_mem_unit;

  localparam int MEM_WORDS = 64;

  logic        clk;
  logic        reset;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op5;
  logic        funct7_5;
  logic [2:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_control_in;
  logic [31:0] alu_result;
  logic        zero;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  exec_mem_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_op         (alu_op),
    .funct3         (funct3),
    .op5            (op5),
    .funct7_5       (funct7_5),
    .alu_control    (alu_control),
    .src_a          (src_a),
    .src_b          (src_b),
    .alu_control_in (alu_control_in),
    .alu_result     (alu_result),
    .zero           (zero),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Vector tables
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic       op5;
    logic       funct7_5;
    logic [2:0] exp_ctrl;
  } dec_vec_t;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } alu_vec_t;

  dec_vec_t dec_tab [12];
  alu_vec_t alu_tab [14];

  // --------------------------------------------------------------------------
  // RAM reference model and expected-read queue
  // --------------------------------------------------------------------------
  logic [31:0] model [MEM_WORDS];

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % MEM_WORDS);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a read address, queue the model's value, then compare once settled.
  task automatic expect_read(input string name, input logic [31:0] addr);
    sb_item_t it;
    mem_addr = addr;
    it.name  = name;
    it.exp   = model[word_of(addr)];
    sb_q.push_back(it);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      it = sb_q.pop_front();
      check32(it.name, mem_rdata, it.exp);
    end
  endtask

  // Write with a check of the old value before the edge and the new one after.
  task automatic do_write(input string name, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_write = 1'b1;
    mem_wdata = data;
    expect_read({name, " pre-edge"}, addr);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    model[word_of(addr)] = data;
    expect_read({name, " post-edge"}, addr);
  endtask

  // --------------------------------------------------------------------------
  // Test
  // --------------------------------------------------------------------------
  initial begin
    //                alu_op funct3  op5   f7_5  expected
    dec_tab[0]  = '{2'b10, 3'b000, 1'b1, 1'b1, 3'b001};
    dec_tab[1]  = '{2'b10, 3'b000, 1'b0, 1'b1, 3'b000};
    dec_tab[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 3'b000};
    dec_tab[3]  = '{2'b10, 3'b010, 1'b1, 1'b0, 3'b101};
    dec_tab[4]  = '{2'b10, 3'b110, 1'b1, 1'b0, 3'b011};
    dec_tab[5]  = '{2'b10, 3'b111, 1'b0, 1'b0, 3'b010};
    dec_tab[6]  = '{2'b10, 3'b001, 1'b1, 1'b1, 3'b000};
    dec_tab[7]  = '{2'b10, 3'b100, 1'b1, 1'b0, 3'b000};
    dec_tab[8]  = '{2'b01, 3'b111, 1'b0, 1'b0, 3'b001};
    dec_tab[9]  = '{2'b00, 3'b010, 1'b1, 1'b1, 3'b000};
    dec_tab[10] = '{2'b11, 3'b000, 1'b1, 1'b1, 3'b000};
    dec_tab[11] = '{2'b11, 3'b110, 1'b0, 1'b0, 3'b000};

    //                ctrl    A             B             result        zero
    alu_tab[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    alu_tab[1]  = '{3'b000, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
    alu_tab[2]  = '{3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    alu_tab[3]  = '{3'b001, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1};
    alu_tab[4]  = '{3'b010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
    alu_tab[5]  = '{3'b011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0};
    alu_tab[6]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    alu_tab[7]  = '{3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    alu_tab[8]  = '{3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    alu_tab[9]  = '{3'b101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    alu_tab[10] = '{3'b101, 32'h00000003, 32'h00000009, 32'h00000001, 1'b0};
    alu_tab[11] = '{3'b100, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 1'b1};
    alu_tab[12] = '{3'b110, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 1'b1};
    alu_tab[13] = '{3'b111, 32'h0000F0F0, 32'h0000FF00, 32'h00000000, 1'b1};

    for (int i = 0; i < MEM_WORDS; i++) model[i] = 32'd0;

    reset          = 1'b1;
    alu_op         = 2'b00;
    funct3         = 3'b000;
    op5            = 1'b0;
    funct7_5       = 1'b0;
    src_a          = 32'd0;
    src_b          = 32'd0;
    alu_control_in = 3'b000;
    mem_write      = 1'b0;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;

    // Reset state: RAM reads 0, ALU/decoder follow their inputs under reset.
    #2;
    expect_read("reset rdata w0", 32'h0);
    expect_read("reset rdata w2", 32'h8);
    check32("reset alu_result", alu_result, 32'd0);
    check32("reset zero", {31'd0, zero}, 32'd1);
    check32("reset alu_control", {29'd0, alu_control}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Decoder sweep
    for (int i = 0; i < 12; i++) begin
      alu_op   = dec_tab[i].alu_op;
      funct3   = dec_tab[i].funct3;
      op5      = dec_tab[i].op5;
      funct7_5 = dec_tab[i].funct7_5;
      #1;
      check32($sformatf("decode[%0d]", i), {29'd0, alu_control}, {29'd0, dec_tab[i].exp_ctrl});
    end

    // ALU sweep
    for (int i = 0; i < 14; i++) begin
      alu_control_in = alu_tab[i].ctrl;
      src_a          = alu_tab[i].a;
      src_b          = alu_tab[i].b;
      #1;
      check32($sformatf("alu_result[%0d]", i), alu_result, alu_tab[i].exp_res);
      check32($sformatf("zero[%0d]", i), {31'd0, zero}, {31'd0, alu_tab[i].exp_zero});
    end

    // RAM write/read and aliasing
    do_write("wr 0x08", 32'h08, 32'hDEADBEEF);
    expect_read("rd 0x0B same word", 32'h0B);
    expect_read("rd 0x108 alias", 32'h108);
    expect_read("rd 0x0C untouched", 32'h0C);
    do_write("wr 0x10C alias", 32'h10C, 32'h0BADF00D);
    expect_read("rd 0x0C after alias wr", 32'h0C);
    expect_read("rd 0x08 kept", 32'h08);

    // Consecutive writes to one word: last wins
    do_write("wr 0x20 first", 32'h20, 32'h11111111);
    do_write("wr 0x20 second", 32'h20, 32'h22222222);
    expect_read("rd 0x20 last wins", 32'h20);
    expect_read("rd 0xFC top word", 32'hFC);

    // Fill words 0-3, then pulse reset between edges
    do_write("fill w0", 32'h00, 32'hA0A0A0A0);
    do_write("fill w1", 32'h04, 32'hA1A1A1A1);
    do_write("fill w2", 32'h08, 32'hA2A2A2A2);
    do_write("fill w3", 32'h0C, 32'hA3A3A3A3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) model[i] = 32'd0;
    expect_read("async clr w0", 32'h00);
    expect_read("async clr w1", 32'h04);
    expect_read("async clr w2", 32'h08);
    expect_read("async clr w3", 32'h0C);
    expect_read("async clr w8", 32'h20);

    // Write held through an edge during reset is ignored
    @(negedge clk);
    mem_write = 1'b1;
    mem_wdata = 32'h55555555;
    mem_addr  = 32'h04;
    @(posedge clk);
    #1;
    expect_read("wr during reset", 32'h04);

    // Deassert with the write still requested: it lands on the next edge
    @(negedge clk);
    reset = 1'b0;
    expect_read("post-reset pre-edge", 32'h04);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    model[word_of(32'h04)] = 32'h55555555;
    expect_read("post-reset first edge", 32'h04);
    expect_read("post-reset w0 still 0", 32'h00);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_exec_mem_unit
`default_nettype wire

// File: doc/exec_mem_unit.md
# exec_mem_unit

Execute/memory datapath slice of the 5-stage RV32I pipeline: ALU-control decoder, 32-bit ALU and word-addressed data RAM. Decoder and ALU are combinational and sit in the Execute stage. The RAM sits in the Memory stage, with a combinational read and a synchronous write.

## Interface
Parameters:
- MEM_WORDS, default 64: RAM depth in 32-bit words; must be a power of two.

Ports:
- clk  in  1  clock; RAM writes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all RAM words.
- alu_op  in  2  operation class from the main decoder.
- funct3  in  3  instr[14:12].
- op5  in  1  instr[5]; 1 = R-type, 0 = I-type.
- funct7_5  in  1  instr[30].
- alu_control  out  3  decoded ALU operation. The pipeline registers it.
- src_a  in  32  ALU operand A.
- src_b  in  32  ALU operand B.
- alu_control_in  in  3  ALU operation for the current Execute instruction (the pipelined alu_control).
- alu_result  out  32  ALU result.
- zero  out  1  1 when alu_result == 0.
- mem_write  in  1  RAM write enable.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data.

## Operation
Decoder (combinational):
- alu_op 00 -> 000 (add; used by loads, stores and jalr).
- alu_op 01 -> 001 (sub; used by branches).
- alu_op 11 -> 000.
- alu_op 10 decodes funct3:
  - 000: 001 if {op5, funct7_5} == 11, otherwise 000.
  - 010 -> 101 (slt).
  - 110 -> 011 (or).
  - 111 -> 010 (and).
  - any other funct3 -> 000.

ALU (combinational, on alu_control_in):
- 000: A + B, modulo 2^32.
- 001: A - B, computed as A + ~B + 1, modulo 2^32.
- 010: A & B.
- 011: A | B.
- 101: signed A < B ? 1 : 0, zero-extended to 32 bits.
- 100, 110, 111: result 0.
- zero = (alu_result == 32'd0).

RAM:
- Word index is mem_addr[log2(MEM_WORDS)+1 : 2]. Bits [1:0] are ignored (no alignment trap). Higher address bits are ignored, so addresses wrap modulo MEM_WORDS.
- mem_rdata = RAM[index], combinational from mem_addr and the current RAM contents.
- Write: when mem_write = 1 and reset = 0 at a rising clk edge, RAM[index] <= mem_wdata. Full-word writes only.

## Timing
- Decoder and ALU outputs are valid in the same cycle as their inputs. They have no state and are unaffected by reset.
- RAM write takes effect at the rising edge. Until that edge, a read of the same address returns the old value; after the edge it returns the new value.
- Reset asserted at any time clears all words to 0 immediately, without waiting for a clock edge, and mem_rdata becomes 0.
- While reset is high, writes are suppressed, including a write coinciding with an edge.
- Writes resume on the first rising edge after reset deasserts.
- Reset values: mem_rdata = 0. alu_result, zero and alu_control follow their inputs at all times.
- Writes to the same index on consecutive edges: the last one wins.

## Structure
- Shared package `exec_pkg`:
  - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
- One natural sub-module: `alu_core`, the combinational ALU plus zero flag. The decoder and RAM stay inline in the top module.

## Test plan
- Decoder sweep:
  - alu_op=10, funct3=000, op5=1, funct7_5=1 -> 001.
  - Same with op5=0, funct7_5=1 -> 000.
  - alu_op=10, funct3=010 -> 101; funct3=110 -> 011; funct3=111 -> 010.
  - alu_op=01 -> 001.
  - alu_op=00 -> 000.
- Arithmetic:
  - 000 with A=0xFFFFFFFF, B=1 -> result 0, zero=1.
  - 001 with A=5, B=7 -> 0xFFFFFFFE, zero=0.
- Logic and compare:
  - 010 with A=0xF0F0, B=0xFF00 -> 0xF000.
  - 011 with the same operands -> 0xFFF0.
  - 101 with A=0xFFFFFFFF (-1), B=1 -> 1.
  - 101 with A=1, B=0xFFFFFFFF -> 0.
- RAM write/read:
  - Write 0xDEADBEEF to addr 0x08 at an edge; mem_rdata shows the old value before the edge and 0xDEADBEEF after it.
  - Addr 0x0B reads the same word.
  - Addr 0x108 with MEM_WORDS=64 aliases to index 2, the same word as 0x08.
- Reset:
  - Fill words 0–3, pulse reset between edges -> all words read 0 immediately.
  - A write with mem_write=1 during reset is ignored.
- Undefined ALU codes 100, 110, 111 -> result 0, zero=1.
